// File: rtl/cd_rx_frame_wr_if.sv
// cd_rx_frame_wr_if
//   Bus bundle between the RX byte stage, the frame writer and the write
//   port of the dual-page frame RAM.
//
//   Signals:
//     in_byte     8           received byte
//     in_valid    1           one-cycle strobe, in_byte is valid
//     in_idle     1           one-cycle strobe, bus idle (frame boundary)
//     wr_byte     8           byte to RAM
//     wr_addr     A_WIDTH+2   byte address in current write page
//     wr_en       1           RAM write strobe
//     switch      1           commit current page (one cycle)
//     wr_flags    8           page flags, valid while switch = 1
//     switch_fail 1           from RAM, one cycle after a rejected switch
//
//   Modports:
//     master  the frame writer
//     slave   the environment (RX byte stage + frame RAM)
interface cd_rx_frame_wr_if #(
    parameter int unsigned A_WIDTH = 6
) ();
    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_idle;
    logic [7:0]         wr_byte;
    logic [A_WIDTH+1:0] wr_addr;
    logic               wr_en;
    logic               switch;
    logic [7:0]         wr_flags;
    logic               switch_fail;

    modport master (
        input  in_byte, in_valid, in_idle, switch_fail,
        output wr_byte, wr_addr, wr_en, switch, wr_flags
    );

    modport slave (
        output in_byte, in_valid, in_idle, switch_fail,
        input  wr_byte, wr_addr, wr_en, switch, wr_flags
    );
endinterface

// File: rtl/cd_rx_frame_wr.sv
// cd_rx_frame_wr
//   Receive-side frame writer in front of the dual-page frame RAM.
//   Accepts deserialized bytes, filters on destination, bounds the length
//   against the page size, writes src/dst/len/data into the RAM page and
//   checks CRC-16/MODBUS over the whole frame. A good frame commits the page
//   with a one-cycle switch; bad, truncated, oversized or lost frames give
//   one-cycle error pulses.
//
//   Ports:
//     clk        system clock, rising edge
//     reset      synchronous, active-high
//     filter     own node address
//     promisc    1 = accept any destination
//     bus        cd_rx_frame_wr_if.master (byte input + RAM write port)
//     crc_err    frame complete but CRC residue non-zero
//     lost_err   RAM rejected the previous switch
//     break_err  bus idle in the middle of a frame
//     ovf_err    length field does not fit in one page
//
//   Frame: src, dst, len, data[len], crc_lo, crc_hi. Bytes src..data are
//   stored at addresses 0..len+2; the CRC bytes are not stored.
module cd_rx_frame_wr #(
    parameter int unsigned A_WIDTH = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        filter,
    input  logic              promisc,
    cd_rx_frame_wr_if.master  bus,
    output logic              crc_err,
    output logic              lost_err,
    output logic              break_err,
    output logic              ovf_err
);

    // Byte counter is wide enough to hold len+4 for any 8-bit len and the
    // page capacity for any A_WIDTH, so the length check never wraps.
    localparam int unsigned CW = (A_WIDTH + 3 > 10) ? A_WIDTH + 3 : 10;
    localparam logic [CW-1:0] PAGE_BYTES = CW'(2 ** (A_WIDTH + 2));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;      // index of the next byte in the frame
    logic [CW-1:0] len_end;    // len+3: number of stored bytes
    logic [15:0]   crc;
    logic          bcast;
    logic          promisc_hit;

    logic [15:0]   crc_first;
    logic [15:0]   crc_next;
    logic [CW-1:0] len_next;
    logic          dst_own;
    logic          dst_bcast;
    logic          dst_reject;
    logic          wr_ok;

    // One byte of CRC-16/MODBUS (reflected 0xA001), all 8 shifts unrolled.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0])
                r = (r >> 1) ^ 16'hA001;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        crc_first  = crc16_byte(16'hFFFF, bus.in_byte);
        crc_next   = crc16_byte(crc, bus.in_byte);
        len_next   = CW'(bus.in_byte) + CW'(3);
        dst_own    = (bus.in_byte == filter);
        dst_bcast  = (bus.in_byte == 8'hFF);
        dst_reject = !promisc && !dst_own && !dst_bcast;

        // In RECV: dst is stored only when accepted, len is always stored,
        // data bytes while below len+3 (len_end is only valid from count 3).
        wr_ok = 1'b0;
        if (count == CW'(1))
            wr_ok = !dst_reject;
        else if (count == CW'(2))
            wr_ok = 1'b1;
        else
            wr_ok = (count < len_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            count        <= '0;
            len_end      <= '0;
            crc          <= '1;
            bcast        <= 1'b0;
            promisc_hit  <= 1'b0;
            bus.wr_byte  <= '0;
            bus.wr_addr  <= '0;
            bus.wr_en    <= 1'b0;
            bus.switch   <= 1'b0;
            bus.wr_flags <= '0;
            crc_err      <= 1'b0;
            lost_err     <= 1'b0;
            break_err    <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            bus.wr_en    <= 1'b0;
            bus.switch   <= 1'b0;
            bus.wr_flags <= '0;
            crc_err      <= 1'b0;
            break_err    <= 1'b0;
            ovf_err      <= 1'b0;
            lost_err     <= bus.switch_fail;

            case (state)
                S_IDLE: begin
                    // in_idle has priority: a byte coinciding with it is dropped.
                    if (bus.in_valid && !bus.in_idle) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= '0;
                        bus.wr_byte <= bus.in_byte;
                        crc         <= crc_first;
                        count       <= CW'(1);
                        state       <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (bus.in_idle) begin
                        break_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (bus.in_valid) begin
                        crc   <= crc_next;
                        count <= count + CW'(1);

                        if (wr_ok) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= count[A_WIDTH+1:0];
                            bus.wr_byte <= bus.in_byte;
                        end

                        if (count == CW'(1)) begin
                            if (dst_reject) begin
                                state <= S_WAIT_IDLE;
                            end else begin
                                bcast       <= dst_bcast;
                                promisc_hit <= promisc && !dst_own && !dst_bcast;
                            end
                        end else if (count == CW'(2)) begin
                            len_end <= len_next;
                            if (len_next > PAGE_BYTES) begin
                                ovf_err <= 1'b1;
                                state   <= S_WAIT_IDLE;
                            end
                        end else if (count == len_end + CW'(1)) begin
                            // crc_hi: residue over the whole frame is zero
                            // when the appended CRC matches.
                            state <= S_IDLE;
                            if (crc_next == 16'h0000) begin
                                bus.switch   <= 1'b1;
                                bus.wr_flags <= {6'b0, promisc_hit, bcast};
                            end else begin
                                crc_err <= 1'b1;
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (bus.in_idle)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
